// File: rtl/tx_frame_sched_if.sv
// Host-side payload handshake for tx_frame_sched.
//   s_valid : host word valid
//   s_data  : host payload, DATA_W bits
//   s_ready : scheduler FIFO not full
// master = host, slave = scheduler.
interface tx_frame_sched_if #(
  parameter int DATA_W = 26
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler in front of tx_top. Buffers host payload words
// in a small FIFO and issues one-cycle start pulses with a stable Din,
// spaced so that a serialiser frame is never overrun, then tracks pipeline
// drain so the host can tell when the serial line is idle.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   enable     : level, 1 allows new frames to launch
//   s_bus      : host valid/ready/data handshake (slave side)
//   tx_start   : one-cycle launch pulse to tx_top start
//   tx_din     : payload to tx_top Din, held between launches
//   busy       : FIFO non-empty or not IDLE
//   line_idle  : IDLE with an empty FIFO (drain complete)
//   frame_cnt  : number of launches issued, wraps at 2^16
module tx_frame_sched #(
  parameter int DATA_W     = 26,
  parameter int FRAME_LEN  = 32,
  parameter int GAP_CYC    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 72
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  tx_frame_sched_if.slave     s_bus,
  output logic                tx_start,
  output logic [DATA_W-1:0]   tx_din,
  output logic                busy,
  output logic                line_idle,
  output logic [15:0]         frame_cnt
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int BIT_W   = $clog2(FRAME_LEN);
  localparam int CNT_MAX = (GAP_CYC > PIPE_LAT) ? GAP_CYC : PIPE_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DRAIN} state_t;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cyc_cnt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              push;
  logic              launch;
  logic              can_launch;

  assign fifo_empty    = (count == '0);
  assign s_bus.s_ready = (count != CW'(FIFO_DEPTH));
  assign push          = s_bus.s_valid & s_bus.s_ready;
  assign can_launch    = enable & ~fifo_empty;

  assign busy      = ~fifo_empty | (state != IDLE);
  assign line_idle = (state == IDLE) & fifo_empty;

  // Launch decision is shared by the FIFO pop and the FSM so both see the
  // same edge; back-to-back launch at end of SHIFT only when there is no gap.
  always_comb begin
    launch = 1'b0;
    case (state)
      IDLE:  launch = can_launch;
      SHIFT: launch = (GAP_CYC == 0) && (bit_cnt == BIT_LAST) && can_launch;
      GAP:   launch = (cyc_cnt == GAP_LAST) && can_launch;
      DRAIN: launch = can_launch;
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (launch) rd_ptr <= rd_ptr + AW'(1);
      case ({push, launch})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
      tx_start  <= 1'b0;
      tx_din    <= '0;
      frame_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      if (launch) begin
        tx_start  <= 1'b1;
        tx_din    <= mem[rd_ptr];
        frame_cnt <= frame_cnt + 16'd1;
        state     <= SHIFT;
        bit_cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              state   <= (GAP_CYC > 0) ? GAP : DRAIN;
              cyc_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          GAP: begin
            if (cyc_cnt == GAP_LAST) begin
              state   <= DRAIN;
              cyc_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (cyc_cnt == DRAIN_LAST) state <= IDLE;
            else                       cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
module tb_tx_frame_sched;

  localparam logic [25:0] WA = 26'h2A5A5A5;
  localparam logic [25:0] WB = 26'h1234567;
  localparam logic [25:0] WC = 26'h0ABCDEF;
  localparam logic [25:0] WD = 26'h3FFFFFF;
  localparam logic [25:0] WE = 26'h0000001;
  localparam logic [25:0] WF = 26'h1555555;
  localparam logic [25:0] WG = 26'h2AAAAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        tx_start;
  logic [25:0] tx_din;
  logic        busy;
  logic        line_idle;
  logic [15:0] frame_cnt;

  logic        enable_g;
  logic        g_tx_start;
  logic [25:0] g_tx_din;
  logic        g_busy;
  logic        g_line_idle;
  logic [15:0] g_frame_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  tx_frame_sched_if #(.DATA_W(26)) bus ();
  tx_frame_sched_if #(.DATA_W(26)) gbus ();

  tx_frame_sched #(
    .DATA_W(26), .FRAME_LEN(32), .GAP_CYC(0), .FIFO_DEPTH(4), .PIPE_LAT(72)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_bus(bus),
    .tx_start(tx_start), .tx_din(tx_din), .busy(busy),
    .line_idle(line_idle), .frame_cnt(frame_cnt)
  );

  tx_frame_sched #(
    .DATA_W(26), .FRAME_LEN(32), .GAP_CYC(5), .FIFO_DEPTH(4), .PIPE_LAT(72)
  ) u_dut_gap (
    .clk(clk), .rst_n(rst_n), .enable(enable_g), .s_bus(gbus),
    .tx_start(g_tx_start), .tx_din(g_tx_din), .busy(g_busy),
    .line_idle(g_line_idle), .frame_cnt(g_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One record = inputs held for n cycles, expected outputs after the last edge.
  typedef struct {
    int unsigned n;
    logic        v;
    logic [25:0] d;
    logic        st;
    logic        rdy;
    logic        idle;
    logic        bsy;
    logic [15:0] fc;
    logic [25:0] din;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int unsigned starts;
    int          first_i;
    int          second_i;
    logic [25:0] first_d;
    logic [25:0] second_d;

    tbl[0]  = '{1,  1'b1, WA,    1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 26'h0};
    tbl[1]  = '{1,  1'b1, WB,    1'b1, 1'b1, 1'b0, 1'b1, 16'd1, WA};
    tbl[2]  = '{1,  1'b1, WC,    1'b0, 1'b1, 1'b0, 1'b1, 16'd1, WA};
    tbl[3]  = '{1,  1'b1, WD,    1'b0, 1'b1, 1'b0, 1'b1, 16'd1, WA};
    tbl[4]  = '{1,  1'b1, WE,    1'b0, 1'b0, 1'b0, 1'b1, 16'd1, WA};
    tbl[5]  = '{1,  1'b1, WF,    1'b0, 1'b0, 1'b0, 1'b1, 16'd1, WA};
    tbl[6]  = '{26, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, WA};
    tbl[7]  = '{1,  1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, WA};
    tbl[8]  = '{1,  1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, WB};
    tbl[9]  = '{1,  1'b1, WG,    1'b0, 1'b0, 1'b0, 1'b1, 16'd2, WB};
    tbl[10] = '{30, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, WB};
    tbl[11] = '{1,  1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, WC};
    tbl[12] = '{32, 1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4, WD};
    tbl[13] = '{32, 1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5, WE};
    tbl[14] = '{32, 1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd6, WG};
    tbl[15] = '{32, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6, WG};
    tbl[16] = '{71, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6, WG};
    tbl[17] = '{1,  1'b0, 26'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd6, WG};

    rst_n = 1'b0;
    enable = 1'b1;
    enable_g = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    gbus.s_valid = 1'b0;
    gbus.s_data = '0;
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_line_idle", 32'(line_idle), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, FIFO fill, overflow attempt, back-to-back stream, drain.
    for (int i = 0; i < 18; i++) begin
      for (int unsigned k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        bus.s_valid = tbl[i].v;
        bus.s_data  = tbl[i].d;
        @(posedge clk);
        #1;
      end
      check($sformatf("row%0d_tx_start", i), 32'(tx_start), 32'(tbl[i].st));
      check($sformatf("row%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d_line_idle", i), 32'(line_idle), 32'(tbl[i].idle));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("row%0d_frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].fc));
      check($sformatf("row%0d_tx_din", i), 32'(tx_din), 32'(tbl[i].din));
    end

    // enable dropped mid-frame with a word still queued.
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = WC;
    @(posedge clk);
    #1;
    check("en_push_line_idle", 32'(line_idle), 32'd0);
    @(negedge clk);
    bus.s_data = WD;
    @(posedge clk);
    #1;
    check("en_lat1_start", 32'(tx_start), 32'd1);
    check("en_lat1_din", 32'(tx_din), 32'(WC));
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) starts++;
    end
    check("en_off_no_start", starts, 32'd0);
    check("en_off_busy", 32'(busy), 32'd1);
    check("en_off_line_idle", 32'(line_idle), 32'd0);
    check("en_off_frame_cnt", 32'(frame_cnt), 32'd7);
    check("en_off_din_held", 32'(tx_din), 32'(WC));
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("en_on_start", 32'(tx_start), 32'd1);
    check("en_on_din", 32'(tx_din), 32'(WD));
    check("en_on_frame_cnt", 32'(frame_cnt), 32'd8);
    repeat (110) @(posedge clk);
    #1;
    check("en_on_final_idle", 32'(line_idle), 32'd1);

    // Reset in the middle of a frame with words buffered.
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = WE;
    @(negedge clk);
    bus.s_data  = WF;
    @(negedge clk);
    bus.s_data  = WG;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("pre_rst_line_idle", 32'(line_idle), 32'd0);
    check("pre_rst_frame_cnt", 32'(frame_cnt), 32'd9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("mid_rst_line_idle", 32'(line_idle), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) starts++;
    end
    check("post_rst_no_start", starts, 32'd0);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("post_rst_line_idle", 32'(line_idle), 32'd1);

    // GAP_CYC=5 instance: two words, start-to-start spacing of 37.
    first_i = -1;
    second_i = -1;
    first_d = '0;
    second_d = '0;
    starts = 0;
    @(negedge clk);
    gbus.s_valid = 1'b1;
    gbus.s_data  = WB;
    @(negedge clk);
    gbus.s_data  = WD;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) gbus.s_valid = 1'b0;
      if (g_tx_start) begin
        starts++;
        if (first_i < 0) begin
          first_i = i;
          first_d = g_tx_din;
        end else if (second_i < 0) begin
          second_i = i;
          second_d = g_tx_din;
        end
      end
    end
    check("gap_start_count", starts, 32'd2);
    check("gap_first_latency", 32'(first_i), 32'd0);
    check("gap_spacing", 32'(second_i - first_i), 32'd37);
    check("gap_first_din", 32'(first_d), 32'(WB));
    check("gap_second_din", 32'(second_d), 32'(WD));
    check("gap_frame_cnt", 32'(g_frame_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Transmit-side frame scheduler that sits in front of tx_top.
- Accepts 26-bit payload words from the host through a valid/ready handshake and buffers them in a small FIFO.
- Issues one-cycle start pulses with stable Din to the Hamming/scrambler/serdes/Manchester chain, spaced so that a serialiser frame is never overrun.
- Tracks pipeline drain so the host knows when the serial line is idle.

Parameters:
- DATA_W, 26, payload width; must match the Hamming encoder K.
- FRAME_LEN, 32, serial bit-cycles per encoded word (start-to-start minimum).
- GAP_CYC, 0, extra idle cycles inserted after each frame (0 = back-to-back).
- FIFO_DEPTH, 4, payload buffer entries, power of 2, >=2.
- PIPE_LAT, 72, cycles from the last frame's final shift cycle until its last Manchester bit leaves Dout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; 1 allows new frames to launch.
- s_valid  in  1  host word valid.
- s_data  in  DATA_W  host payload.
- s_ready  out  1  FIFO not full.
- tx_start  out  1  one-cycle launch pulse to tx_top start.
- tx_din  out  DATA_W  payload to tx_top Din; held stable between pulses.
- busy  out  1  FIFO non-empty or state != IDLE.
- line_idle  out  1  1 when IDLE, FIFO empty and drain complete.
- frame_cnt  out  16  count of tx_start pulses issued.

Behaviour:
- Reset values (async, immediate):
  - tx_start=0, tx_din=0, frame_cnt=0.
  - FIFO emptied, so s_ready=1.
  - state=IDLE, busy=0, line_idle=1.
- FIFO:
  - Push on s_valid&s_ready; pop on each launch.
  - Push and pop in the same cycle leaves the occupancy unchanged.
  - s_ready = (count != FIFO_DEPTH), computed combinationally from registered count.
  - No push when full. Data beyond the handshake is ignored.
- States: IDLE, SHIFT, GAP, DRAIN. bit_cnt is log2(FRAME_LEN) bits; gap/drain counter is sized for max(GAP_CYC, PIPE_LAT).
- Launch condition L = enable & FIFO non-empty, evaluated in IDLE, at the end of SHIFT (when GAP_CYC=0), at the end of GAP, or anywhere in DRAIN.
- On a launch edge:
  - tx_start=1 for the following cycle only.
  - tx_din <= FIFO head; pop.
  - frame_cnt += 1, wrapping at 2^16.
  - state=SHIFT, bit_cnt=0.
- SHIFT:
  - bit_cnt increments each cycle.
  - At bit_cnt==FRAME_LEN-1:
    - if GAP_CYC>0, go to GAP with counter 0;
    - else if L, launch (back-to-back);
    - else go to DRAIN with counter 0.
- GAP: counts GAP_CYC cycles. Then launch if L, else go to DRAIN.
- DRAIN:
  - Counts PIPE_LAT cycles, then goes to IDLE.
  - A launch during DRAIN aborts the drain (goes to SHIFT).
- Timing:
  - Start-to-start spacing while streaming is exactly FRAME_LEN+GAP_CYC cycles.
  - Latency from an accepted push (FIFO empty, IDLE, enable=1) to tx_start high is 1 cycle.
- tx_din changes only on a launch edge and is never modified mid-frame.
- enable deasserted mid-frame: the current SHIFT/GAP completes, no new launch occurs, and the block drains to IDLE. Re-asserting enable resumes from the FIFO head; no word is lost.
- line_idle = (state==IDLE) & FIFO empty. It deasserts the cycle after a push into an empty FIFO.
- Reset mid-frame: all state is cleared asynchronously and buffered words are discarded. tx_start is 0 during and after reset until a new launch.

Test Plan:
- Reset, enable=1, push 0x2A5A5A5 once -> tx_start high exactly 1 cycle, 1 cycle after accept; tx_din=0x2A5A5A5; frame_cnt=1; line_idle returns to 1 exactly 32+72 cycles after tx_start.
- Push 4 words back-to-back with GAP_CYC=0 -> 4 tx_start pulses 32 cycles apart; tx_din sequence matches push order; s_ready low after the 4th accept only if no pop has occurred yet.
- Hold s_valid with 8 words, FIFO_DEPTH=4 -> s_ready deasserts when full; all 8 words are launched in order with none dropped or duplicated; frame_cnt=8.
- GAP_CYC=5, two words -> start-to-start spacing is 37 cycles; no tx_start during GAP.
- enable=0 at bit_cnt 10 of frame 1 with 2 words queued -> frame 1 completes, no further start, busy=1; enable=1 later -> next start issues 1 cycle after the enabled IDLE/DRAIN cycle and carries word 2.
- Assert rst_n=0 at bit_cnt 15 with 3 words queued -> tx_start=0, frame_cnt=0, s_ready=1, line_idle=1 immediately; after release, no start occurs without a new push.
